// File: rtl/i2si_deserializer_param.sv
// i2si_deserializer_param: I2S / left-justified receive deserializer, MSB-first.
// Optional build macro I2SI_FRAME_ERR_EN enables slot-length mismatch flag on out_ferr.
module i2si_deserializer_param #(
    parameter int DATA_W   = 16,
    parameter int MAX_SLOT = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sck_transition,
    input  logic              in_ws,
    input  logic              in_sd,
    input  logic              rf_i2si_en,
    input  logic              rf_i2si_lj,
    output logic [DATA_W-1:0] out_lft,
    output logic [DATA_W-1:0] out_rgt,
    output logic              out_xfc,
    output logic              out_ferr
);

    localparam int CNT_W = $clog2(MAX_SLOT + 1);

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        LEFT,
        RIGHT
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic              lj_q;
    logic              ws_d;
    logic              ews_prev;
    logic              ews;
    logic              smp;
    logic              bnd;
    logic              fall;
    logic              rise;

    logic              open_slot;
    logic              shift_bit;
    logic              close_lft;
    logic              close_rgt;

    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] sreg;
    logic [DATA_W-1:0] sreg_ins;
    logic [DATA_W-1:0] stg;
    logic [DATA_W-1:0] rgt_hold;
    logic              lft_ok;
    logic              pend;

    // I2S reuses the LJ datapath by delaying ws one sample
    assign smp  = rf_i2si_en && sck_transition && (state != IDLE);
    assign ews  = lj_q ? in_ws : ws_d;
    assign bnd  = smp && (ews != ews_prev);
    assign fall = bnd && !ews;
    assign rise = bnd && ews;

    // State register; disable wins over any coincident sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (!rf_i2si_en) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: sync on ews 1->0, then alternate on boundaries
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = SYNC;
            SYNC:    if (fall) state_nxt = LEFT;
            LEFT:    if (rise) state_nxt = RIGHT;
            RIGHT:   if (fall) state_nxt = LEFT;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: slot open/close and shift strobes
    always_comb begin
        open_slot = 1'b0;
        shift_bit = 1'b0;
        close_lft = 1'b0;
        close_rgt = 1'b0;
        unique case (state)
            IDLE: ;
            SYNC: open_slot = fall;
            LEFT: begin
                close_lft = rise;
                open_slot = rise;
                shift_bit = smp && !bnd;
            end
            RIGHT: begin
                close_rgt = fall;
                open_slot = fall;
                shift_bit = smp && !bnd;
            end
            default: ;
        endcase
    end

    // Mode latch while idle; ws history kept only while enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lj_q     <= 1'b0;
            ws_d     <= 1'b0;
            ews_prev <= 1'b0;
        end else begin
            if (state == IDLE) begin
                lj_q <= rf_i2si_lj;
            end
            if (!rf_i2si_en || state == IDLE) begin
                ws_d     <= 1'b0;
                ews_prev <= 1'b0;
            end else if (smp) begin
                ws_d     <= in_ws;
                ews_prev <= ews;
            end
        end
    end

    // Bit at slot index cnt lands at DATA_W-1-cnt; index >= DATA_W is dropped
    always_comb begin
        sreg_ins = sreg;
        for (int i = 0; i < DATA_W; i++) begin
            if (cnt == CNT_W'(DATA_W - 1 - i)) begin
                sreg_ins[i] = in_sd;
            end
        end
    end

    // Slot assembly, left staging and right close hand-off
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            sreg     <= '0;
            stg      <= '0;
            rgt_hold <= '0;
            lft_ok   <= 1'b0;
            pend     <= 1'b0;
        end else if (!rf_i2si_en) begin
            cnt      <= '0;
            sreg     <= '0;
            stg      <= '0;
            rgt_hold <= '0;
            lft_ok   <= 1'b0;
            pend     <= 1'b0;
        end else begin
            pend <= 1'b0;
            if (open_slot) begin
                sreg <= {in_sd, {(DATA_W - 1){1'b0}}};
                cnt  <= CNT_W'(1);
            end else if (shift_bit) begin
                sreg <= sreg_ins;
                if (cnt != CNT_W'(MAX_SLOT)) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
            if (close_lft) begin
                stg    <= sreg;
                lft_ok <= 1'b1;
            end
            if (close_rgt && lft_ok) begin
                rgt_hold <= sreg;
                pend     <= 1'b1;
            end
        end
    end

    // Publish the pair one clk after the closing boundary sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_lft <= '0;
            out_rgt <= '0;
            out_xfc <= 1'b0;
        end else begin
            out_xfc <= pend && rf_i2si_en;
            if (pend && rf_i2si_en) begin
                out_lft <= stg;
                out_rgt <= rgt_hold;
            end
        end
    end

`ifdef I2SI_FRAME_ERR_EN
    logic [CNT_W-1:0] prev_cnt;
    logic             have_prev;
    logic             ferr_q;

    // Sticky flag when a closed slot length differs from the previous one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_cnt  <= '0;
            have_prev <= 1'b0;
            ferr_q    <= 1'b0;
        end else if (!rf_i2si_en) begin
            prev_cnt  <= '0;
            have_prev <= 1'b0;
            ferr_q    <= 1'b0;
        end else if (close_lft || close_rgt) begin
            if (have_prev && cnt != prev_cnt) begin
                ferr_q <= 1'b1;
            end
            prev_cnt  <= cnt;
            have_prev <= 1'b1;
        end
    end

    assign out_ferr = ferr_q;
`else
    assign out_ferr = 1'b0;
`endif

endmodule

// File: tb/tb_i2si_deserializer_param.sv
// Bench for i2si_deserializer_param: 16- and 24-bit instances share one stimulus.
// Table segments, directed disable/reset sequences and random frames vs a model.
`timescale 1ns/1ps
module tb_i2si_deserializer_param;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sck_transition;
    logic        in_ws;
    logic        in_sd;
    logic        en;
    logic        lj;
    logic [15:0] lft_a;
    logic [15:0] rgt_a;
    logic        xfc_a;
    logic        ferr_a;
    logic [23:0] lft_b;
    logic [23:0] rgt_b;
    logic        xfc_b;
    logic        ferr_b;

    always #5 clk = ~clk;

    i2si_deserializer_param #(.DATA_W(16), .MAX_SLOT(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .sck_transition(sck_transition),
        .in_ws(in_ws), .in_sd(in_sd), .rf_i2si_en(en), .rf_i2si_lj(lj),
        .out_lft(lft_a), .out_rgt(rgt_a), .out_xfc(xfc_a), .out_ferr(ferr_a)
    );

    i2si_deserializer_param #(.DATA_W(24), .MAX_SLOT(32)) dut_b (
        .clk(clk), .rst_n(rst_n), .sck_transition(sck_transition),
        .in_ws(in_ws), .in_sd(in_sd), .rf_i2si_en(en), .rf_i2si_lj(lj),
        .out_lft(lft_b), .out_rgt(rgt_b), .out_xfc(xfc_b), .out_ferr(ferr_b)
    );

    typedef struct {
        logic        ws;
        int          n;
        logic [31:0] val;
        int          cl;
    } slot_t;

    typedef struct {
        logic [15:0] l16;
        logic [15:0] r16;
        logic [23:0] l24;
        logic [23:0] r24;
        logic        ferr;
    } pair_t;

    typedef struct {
        pair_t p;
        int    cyc;
    } exp_t;

    typedef struct {
        int          seg;
        logic        lj;
        int          p;
        int          nl;
        logic [31:0] vl;
        int          nr;
        logic [31:0] vr;
        logic [15:0] l16;
        logic [15:0] r16;
        logic [23:0] l24;
        logic [23:0] r24;
    } vec_t;

    localparam int NV = 10;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    exp_t  mq[$];
    exp_t  me;
    pair_t last;
    slot_t sq[$];
    pair_t pq[$];
    vec_t  tbl[NV];
    int    prev_len;
    bit    have_prev;
    bit    ferr_acc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every xfc must match the next queued pair and cycle
    always @(negedge clk) begin
        if (rst_n && (xfc_a || xfc_b)) begin
            if (mq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_xfc: a=%b b=%b at cycle %0d",
                         xfc_a, xfc_b, cyc);
            end else begin
                me = mq.pop_front();
                chk("xfc_a", 32'(xfc_a), 32'd1);
                chk("xfc_b", 32'(xfc_b), 32'd1);
                chk("xfc_cycle", cyc, me.cyc);
                chk("lft16", 32'(lft_a), 32'(me.p.l16));
                chk("rgt16", 32'(rgt_a), 32'(me.p.r16));
                chk("lft24", 32'(lft_b), 32'(me.p.l24));
                chk("rgt24", 32'(rgt_b), 32'(me.p.r24));
                chk("ferr16_at_xfc", 32'(ferr_a), 32'(me.p.ferr));
                chk("ferr24_at_xfc", 32'(ferr_b), 32'(me.p.ferr));
                last = me.p;
            end
        end
    end

    function automatic logic [31:0] align(input logic [31:0] v,
                                          input int n, input int w);
        if (n >= w) return v >> (n - w);
        return v << (w - n);
    endfunction

    function automatic logic [31:0] mask(input int n);
        logic [63:0] t;
        t = (64'd1 << n) - 64'd1;
        return t[31:0];
    endfunction

    task automatic upd_len(input int n);
        if (have_prev && n != prev_len) ferr_acc = 1'b1;
        prev_len  = n;
        have_prev = 1'b1;
    endtask

    task automatic add_slot(input logic ws, input int n,
                            input logic [31:0] val, input int cl);
        slot_t s;
        s.ws  = ws;
        s.n   = n;
        s.val = val;
        s.cl  = cl;
        sq.push_back(s);
    endtask

    task automatic begin_seg(input bit mid);
        sq.delete();
        pq.delete();
        have_prev = 1'b0;
        ferr_acc  = 1'b0;
        prev_len  = 0;
        if (mid) begin
            add_slot(1'b0, 8, 32'h5A, -1);
            add_slot(1'b1, 16, 32'hBEEF, -1);
        end else begin
            add_slot(1'b1, 4, 32'h9, -1);
        end
    endtask

    task automatic add_frame(input int nl, input logic [31:0] vl,
                             input int nr, input logic [31:0] vr,
                             input logic [15:0] l16, input logic [15:0] r16,
                             input logic [23:0] l24, input logic [23:0] r24);
        pair_t p;
        add_slot(1'b0, nl, vl, (pq.size() > 0) ? pq.size() - 1 : -1);
        add_slot(1'b1, nr, vr, -1);
        upd_len(nl);
        upd_len(nr);
        p.l16 = l16;
        p.r16 = r16;
        p.l24 = l24;
        p.r24 = r24;
`ifdef I2SI_FRAME_ERR_EN
        p.ferr = ferr_acc;
`else
        p.ferr = 1'b0;
`endif
        pq.push_back(p);
    endtask

    task automatic add_model_frame(input int nl, input logic [31:0] vl,
                                   input int nr, input logic [31:0] vr);
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        a = align(vl, nl, 16);
        b = align(vr, nr, 16);
        c = align(vl, nl, 24);
        d = align(vr, nr, 24);
        add_frame(nl, vl, nr, vr, a[15:0], b[15:0], c[23:0], d[23:0]);
    endtask

    task automatic end_seg();
        add_slot(1'b0, 3, 32'h5, pq.size() - 1);
    endtask

    // Serialise the slot list; I2S ws leads the data by one sample
    task automatic drive(input int p, input logic mode_lj);
        logic ws_s[$];
        logic sd_s[$];
        int   cl_s[$];
        int   lst;
        exp_t x;
        foreach (sq[j]) begin
            for (int b = 0; b < sq[j].n; b++) begin
                ws_s.push_back(sq[j].ws);
                sd_s.push_back(sq[j].val[sq[j].n - 1 - b]);
                cl_s.push_back((b == 0) ? sq[j].cl : -1);
            end
        end
        lst = ws_s.size() - 1;
        for (int k = 0; k <= lst; k++) begin
            sck_transition = 1'b0;
            repeat (p - 1) @(negedge clk);
            sck_transition = 1'b1;
            in_sd = sd_s[k];
            in_ws = mode_lj ? ws_s[k] : ws_s[(k < lst) ? k + 1 : lst];
            @(negedge clk);
            if (cl_s[k] >= 0) begin
                x.p   = pq[cl_s[k]];
                x.cyc = cyc + 1;
                mq.push_back(x);
            end
        end
        sck_transition = 1'b0;
    endtask

    task automatic run_seg(input logic mode_lj, input int p);
        logic fe;
`ifdef I2SI_FRAME_ERR_EN
        fe = ferr_acc;
`else
        fe = 1'b0;
`endif
        lj = mode_lj;
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        drive(p, mode_lj);
        for (int i = 0; i < 20 && mq.size() != 0; i++) @(negedge clk);
        checks++;
        if (mq.size() != 0) begin
            errors++;
            $display("FAIL missing_xfc: %0d pairs pending at cycle %0d",
                     mq.size(), cyc);
            mq.delete();
        end
        chk("ferr16_final", 32'(ferr_a), 32'(fe));
        chk("ferr24_final", 32'(ferr_b), 32'(fe));
        en = 1'b0;
        repeat (3) @(negedge clk);
        chk("ferr16_cleared", 32'(ferr_a), 32'd0);
        chk("hold_lft16", 32'(lft_a), 32'(last.l16));
        chk("hold_rgt16", 32'(rgt_a), 32'(last.r16));
        chk("hold_lft24", 32'(lft_b), 32'(last.l24));
        chk("hold_rgt24", 32'(rgt_b), 32'(last.r24));
    endtask

    task automatic setv(input int i, input int seg, input logic l,
                        input int p, input int nl, input logic [31:0] vl,
                        input int nr, input logic [31:0] vr,
                        input logic [15:0] l16, input logic [15:0] r16,
                        input logic [23:0] l24, input logic [23:0] r24);
        tbl[i].seg = seg;
        tbl[i].lj  = l;
        tbl[i].p   = p;
        tbl[i].nl  = nl;
        tbl[i].vl  = vl;
        tbl[i].nr  = nr;
        tbl[i].vr  = vr;
        tbl[i].l16 = l16;
        tbl[i].r16 = r16;
        tbl[i].l24 = l24;
        tbl[i].r24 = r24;
    endtask

    initial begin
        int n0;
        int nl;
        int nr;
        int nf;
        logic m;

        setv(0, 0, 1'b0, 80, 16, 32'hAAAA, 16, 32'hFFFF,
             16'hAAAA, 16'hFFFF, 24'hAAAA00, 24'hFFFF00);
        setv(1, 0, 1'b0, 80, 16, 32'h1478, 16, 32'hA3B9,
             16'h1478, 16'hA3B9, 24'h147800, 24'hA3B900);
        setv(2, 0, 1'b0, 80, 16, 32'hCDD7, 16, 32'hBABA,
             16'hCDD7, 16'hBABA, 24'hCDD700, 24'hBABA00);
        setv(3, 1, 1'b1, 2, 24, 32'h123456, 24, 32'hABCDEF,
             16'h1234, 16'hABCD, 24'h123456, 24'hABCDEF);
        setv(4, 2, 1'b0, 1, 32, 32'h73985A5A, 12, 32'hABC,
             16'h7398, 16'hABC0, 24'h73985A, 24'hABC000);
        setv(5, 3, 1'b1, 1, 8, 32'hA5, 8, 32'h3C,
             16'hA500, 16'h3C00, 24'hA50000, 24'h3C0000);
        setv(6, 4, 1'b0, 3, 20, 32'hFEDCB, 20, 32'h13579,
             16'hFEDC, 16'h1357, 24'hFEDCB0, 24'h135790);
        setv(7, 5, 1'b0, 1, 16, 32'h1111, 16, 32'h2222,
             16'h1111, 16'h2222, 24'h111100, 24'h222200);
        setv(8, 5, 1'b0, 1, 16, 32'h3333, 15, 32'h4444,
             16'h3333, 16'h8888, 24'h333300, 24'h888800);
        setv(9, 5, 1'b0, 1, 16, 32'h5555, 16, 32'h6666,
             16'h5555, 16'h6666, 24'h555500, 24'h666600);

        last           = '{16'h0, 16'h0, 24'h0, 24'h0, 1'b0};
        rst_n          = 1'b0;
        en             = 1'b0;
        lj             = 1'b0;
        sck_transition = 1'b0;
        in_ws          = 1'b0;
        in_sd          = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_lft16", 32'(lft_a), 32'd0);
        chk("reset_rgt16", 32'(rgt_a), 32'd0);
        chk("reset_lft24", 32'(lft_b), 32'd0);
        chk("reset_rgt24", 32'(rgt_b), 32'd0);
        chk("reset_xfc", 32'({xfc_a, xfc_b}), 32'd0);
        chk("reset_ferr", 32'({ferr_a, ferr_b}), 32'd0);

        for (int i = 0; i < NV; i++) begin
            if (i == 0 || tbl[i].seg != tbl[i - 1].seg) begin_seg(1'b0);
            add_frame(tbl[i].nl, tbl[i].vl, tbl[i].nr, tbl[i].vr,
                      tbl[i].l16, tbl[i].r16, tbl[i].l24, tbl[i].r24);
            if (i == NV - 1 || tbl[i + 1].seg != tbl[i].seg) begin
                end_seg();
                run_seg(tbl[i].lj, tbl[i].p);
            end
        end

        // Re-enable mid-left: partial slots before the first 1->0 are ignored
        begin_seg(1'b1);
        add_model_frame(16, 32'h0F1E, 16, 32'h2D3C);
        end_seg();
        run_seg(1'b0, 2);
        begin_seg(1'b1);
        add_model_frame(24, 32'h9ABCDE, 24, 32'h13579B);
        end_seg();
        run_seg(1'b1, 1);

        // Reset mid-frame clears outputs at once
        sq.delete();
        pq.delete();
        add_slot(1'b1, 6, 32'h2D, -1);
        add_slot(1'b0, 10, 32'h155, -1);
        lj = 1'b0;
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        drive(2, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_lft16", 32'(lft_a), 32'd0);
        chk("rst_mid_rgt16", 32'(rgt_a), 32'd0);
        chk("rst_mid_lft24", 32'(lft_b), 32'd0);
        chk("rst_mid_rgt24", 32'(rgt_b), 32'd0);
        chk("rst_mid_xfc", 32'({xfc_a, xfc_b}), 32'd0);
        @(negedge clk);
        en    = 1'b0;
        rst_n = 1'b1;
        last  = '{16'h0, 16'h0, 24'h0, 24'h0, 1'b0};
        @(negedge clk);
        begin_seg(1'b1);
        add_model_frame(16, 32'hC0DE, 16, 32'hFACE);
        end_seg();
        run_seg(1'b0, 1);

        // Random frames against the alignment model
        for (int r = 0; r < 6; r++) begin
            m  = 1'($urandom_range(0, 1));
            nf = $urandom_range(2, 3);
            n0 = $urandom_range(8, 32);
            begin_seg(1'b0);
            for (int f = 0; f < nf; f++) begin
                nl = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 32) : n0;
                nr = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 32) : n0;
                add_model_frame(nl, $urandom() & mask(nl),
                                nr, $urandom() & mask(nr));
            end
            end_seg();
            run_seg(m, $urandom_range(1, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
